// File: rtl/lock_pkg.sv
// Shared types for the canal lock controller: FSM states, side encoding and switch bundle.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARRIVE = 2'd1,
        POUND  = 2'd2,
        DEPART = 2'd3
    } state_e;

    typedef enum logic {
        SIDE_OUTER = 1'b0,
        SIDE_INNER = 1'b1
    } side_e;

    // One bit per sampled switch; edge detection works on the whole bundle.
    typedef struct packed {
        logic outer_arrival;
        logic inner_arrival;
        logic outer_door;
        logic inner_door;
        logic inc;
        logic dec;
    } sw_t;

    function automatic side_e other_side(input side_e s);
        return (s == SIDE_OUTER) ? SIDE_INNER : SIDE_OUTER;
    endfunction

endpackage

// File: rtl/canal_lock_ctrl_if.sv
// Switch inputs and status outputs of one canal lock controller.
interface canal_lock_ctrl_if #(
    parameter int unsigned LW = 17
) ();
    logic          tick;
    logic          outer_arrival_sw;
    logic          inner_arrival_sw;
    logic          outer_door_sw;
    logic          inner_door_sw;
    logic          inc_water_level;
    logic          dec_water_level;
    logic [LW-1:0] water_level;
    logic          outer_door_openable_led;
    logic          inner_door_openable_led;
    logic          outer_gondola_led;
    logic          inner_gondola_led;
    logic          busy;
    logic          wrong_cmd;

    modport master (
        output tick, outer_arrival_sw, inner_arrival_sw, outer_door_sw, inner_door_sw,
               inc_water_level, dec_water_level,
        input  water_level, outer_door_openable_led, inner_door_openable_led,
               outer_gondola_led, inner_gondola_led, busy, wrong_cmd
    );

    modport slave (
        input  tick, outer_arrival_sw, inner_arrival_sw, outer_door_sw, inner_door_sw,
               inc_water_level, dec_water_level,
        output water_level, outer_door_openable_led, inner_door_openable_led,
               outer_gondola_led, inner_gondola_led, busy, wrong_cmd
    );
endinterface

// File: rtl/lock_level_tracker.sv
// Pound water level register with saturating fill/drain steps and door-openable compares.
// Build option LOCK_AUTO_LEVEL_EN: auto-steps toward the exit side on each tick while in POUND.
module lock_level_tracker #(
    parameter int unsigned LW          = 17,
    parameter int unsigned OUTER_LEVEL = 0,
    parameter int unsigned INNER_LEVEL = 2800,
    parameter int unsigned TOLERANCE   = 168,
    parameter int unsigned FILL_STEP   = 350,
    parameter int unsigned DRAIN_STEP  = 400
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_ev,
    input  logic          dec_ev,
`ifdef LOCK_AUTO_LEVEL_EN
    input  logic          auto_en,
    input  logic          tick,
    input  logic          to_inner,
`endif
    output logic [LW-1:0] level,
    output logic          outer_openable_c,
    output logic          inner_openable_c
);
    localparam int unsigned W1         = LW + 1;
    localparam int unsigned INNER_OPEN = (INNER_LEVEL > TOLERANCE) ? INNER_LEVEL - TOLERANCE : 0;

    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] up_sat_c, dn_sat_c;
    logic [W1-1:0] lvl_x, up_x;
    logic          do_fill_c, do_drain_c;

    // One guard bit keeps the step arithmetic from wrapping.
    assign lvl_x    = {1'b0, level_q};
    assign up_x     = lvl_x + W1'(FILL_STEP);
    assign up_sat_c = (up_x >= W1'(INNER_LEVEL)) ? LW'(INNER_LEVEL) : up_x[LW-1:0];
    assign dn_sat_c = (lvl_x < W1'(OUTER_LEVEL + DRAIN_STEP)) ? LW'(OUTER_LEVEL)
                                                              : LW'(lvl_x - W1'(DRAIN_STEP));

    always_comb begin
        do_fill_c  = inc_ev & ~dec_ev;
        do_drain_c = dec_ev & ~inc_ev;
`ifdef LOCK_AUTO_LEVEL_EN
        if (auto_en) begin
            do_fill_c  = tick & to_inner;
            do_drain_c = tick & ~to_inner;
        end
`endif
        level_d = level_q;
        if (do_fill_c) begin
            level_d = up_sat_c;
        end else if (do_drain_c) begin
            level_d = dn_sat_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            level_q <= LW'(OUTER_LEVEL);
        end else begin
            level_q <= level_d;
        end
    end

    assign level            = level_q;
    assign outer_openable_c = (lvl_x <= W1'(OUTER_LEVEL + TOLERANCE));
    assign inner_openable_c = (lvl_x >= W1'(INNER_OPEN));

endmodule

// File: rtl/canal_lock_ctrl.sv
// Single-lock controller: edge-detects switches and sequences one gondola at a time through the pound.
// Build option LOCK_AUTO_LEVEL_EN: water auto-levels toward the exit side while in POUND.
module canal_lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned LW          = 17,
    parameter int unsigned OUTER_LEVEL = 0,
    parameter int unsigned INNER_LEVEL = 2800,
    parameter int unsigned TOLERANCE   = 168,
    parameter int unsigned FILL_STEP   = 350,
    parameter int unsigned DRAIN_STEP  = 400,
    parameter int unsigned ARR_DELAY   = 5,
    parameter int unsigned DEPT_DELAY  = 5
) (
    input logic             clk,
    input logic             reset,
    canal_lock_ctrl_if.slave bus
);
    localparam int unsigned TMAX = (ARR_DELAY > DEPT_DELAY) ? ARR_DELAY : DEPT_DELAY;
    localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

    state_e        state_q, state_d;
    side_e         dir_q, dir_d, x_side_c, serve_c;
    logic [1:0]    pending_q, pending_d, arr_c, pend_all_c;
    logic [TW-1:0] timer_q, timer_d;
    logic          outer_led_q, outer_led_d, inner_led_q, inner_led_d;
    logic          wrong_cmd_q, wrong_cmd_d;
    sw_t           sw_d, sw_q, ev_c;
    logic          outer_open_c, inner_open_c;
    logic          s_door_c, x_door_c, s_open_c, x_open_c;
    logic [LW-1:0] level_w;

    assign sw_d = '{outer_arrival: bus.outer_arrival_sw, inner_arrival: bus.inner_arrival_sw,
                    outer_door:    bus.outer_door_sw,    inner_door:    bus.inner_door_sw,
                    inc:           bus.inc_water_level,  dec:           bus.dec_water_level};
    assign ev_c = sw_d & ~sw_q;

    // Entry side S is dir_q; exit side X is the opposite door.
    assign x_side_c = other_side(dir_q);
    assign arr_c    = {ev_c.inner_arrival, ev_c.outer_arrival};
    assign s_door_c = (dir_q == SIDE_OUTER) ? ev_c.outer_door : ev_c.inner_door;
    assign x_door_c = (dir_q == SIDE_OUTER) ? ev_c.inner_door : ev_c.outer_door;
    assign s_open_c = (dir_q == SIDE_OUTER) ? outer_open_c : inner_open_c;
    assign x_open_c = (dir_q == SIDE_OUTER) ? inner_open_c : outer_open_c;

    lock_level_tracker #(
        .LW          (LW),
        .OUTER_LEVEL (OUTER_LEVEL),
        .INNER_LEVEL (INNER_LEVEL),
        .TOLERANCE   (TOLERANCE),
        .FILL_STEP   (FILL_STEP),
        .DRAIN_STEP  (DRAIN_STEP)
    ) u_level (
        .clk              (clk),
        .reset            (reset),
        .inc_ev           (ev_c.inc),
        .dec_ev           (ev_c.dec),
`ifdef LOCK_AUTO_LEVEL_EN
        .auto_en          (state_q == POUND),
        .tick             (bus.tick),
        .to_inner         (x_side_c == SIDE_INNER),
`endif
        .level            (level_w),
        .outer_openable_c (outer_open_c),
        .inner_openable_c (inner_open_c)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pending_d   = pending_q;
        timer_d     = timer_q;
        outer_led_d = outer_led_q;
        inner_led_d = inner_led_q;
        wrong_cmd_d = 1'b0;
        serve_c     = SIDE_OUTER;
        pend_all_c  = pending_q | arr_c;

        if (bus.tick && (timer_q < TW'(TMAX))) begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            IDLE: begin
                // Simultaneous arrivals: outer is served, inner waits.
                if (ev_c.outer_arrival) begin
                    state_d     = ARRIVE;
                    dir_d       = SIDE_OUTER;
                    outer_led_d = 1'b1;
                    timer_d     = '0;
                    pending_d   = {ev_c.inner_arrival, 1'b0};
                end else if (ev_c.inner_arrival) begin
                    state_d     = ARRIVE;
                    dir_d       = SIDE_INNER;
                    inner_led_d = 1'b1;
                    timer_d     = '0;
                end
            end
            ARRIVE: begin
                pending_d   = pend_all_c;
                wrong_cmd_d = x_door_c;
                if (s_door_c) begin
                    if ((timer_q >= TW'(ARR_DELAY)) && s_open_c) begin
                        state_d     = POUND;
                        outer_led_d = 1'b1;
                        inner_led_d = 1'b1;
                    end else begin
                        wrong_cmd_d = 1'b1;
                    end
                end
            end
            POUND: begin
                pending_d   = pend_all_c;
                wrong_cmd_d = s_door_c;
                if (x_door_c) begin
                    if (x_open_c) begin
                        state_d     = DEPART;
                        timer_d     = '0;
                        outer_led_d = (x_side_c == SIDE_OUTER);
                        inner_led_d = (x_side_c == SIDE_INNER);
                    end else begin
                        wrong_cmd_d = 1'b1;
                    end
                end
            end
            DEPART: begin
                pending_d   = pend_all_c;
                wrong_cmd_d = s_door_c | x_door_c;
                if (timer_q >= TW'(DEPT_DELAY)) begin
                    outer_led_d = 1'b0;
                    inner_led_d = 1'b0;
                    if (pend_all_c != 2'b00) begin
                        // Both waiting: alternate away from the side just served.
                        serve_c = (pend_all_c == 2'b11) ? x_side_c
                                : (pend_all_c[SIDE_INNER] ? SIDE_INNER : SIDE_OUTER);
                        state_d            = ARRIVE;
                        dir_d              = serve_c;
                        timer_d            = '0;
                        pending_d[serve_c] = 1'b0;
                        if (serve_c == SIDE_OUTER) begin
                            outer_led_d = 1'b1;
                        end else begin
                            inner_led_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            dir_q       <= SIDE_OUTER;
            pending_q   <= '0;
            timer_q     <= '0;
            outer_led_q <= 1'b0;
            inner_led_q <= 1'b0;
            wrong_cmd_q <= 1'b0;
            sw_q        <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            outer_led_q <= outer_led_d;
            inner_led_q <= inner_led_d;
            wrong_cmd_q <= wrong_cmd_d;
            sw_q        <= sw_d;
        end
    end

    assign bus.water_level             = level_w;
    assign bus.outer_door_openable_led = outer_open_c;
    assign bus.inner_door_openable_led = inner_open_c;
    assign bus.outer_gondola_led       = outer_led_q;
    assign bus.inner_gondola_led       = inner_led_q;
    assign bus.busy                    = (state_q != IDLE);
    assign bus.wrong_cmd               = wrong_cmd_q;

endmodule

// File: tb/tb_canal_lock_ctrl.sv
// Directed scenarios plus random switch traffic, checked every cycle against a behavioural lock model.
module tb_canal_lock_ctrl;
    localparam int LVL_IN = 2800;
    localparam int TOL    = 168;
    localparam int FILL   = 350;
    localparam int DRAIN  = 400;
    localparam int DLY    = 5;

    localparam logic [6:0] OA = 7'b1000000, IA = 7'b0100000, OD = 7'b0010000, ID = 7'b0001000;
    localparam logic [6:0] INC = 7'b0000100, DEC = 7'b0000010, TK = 7'b0000001, NONE = 7'b0;

    localparam int P_FREE = 0, P_WAIT = 1, P_POUND = 2, P_EXIT = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    canal_lock_ctrl_if #(.LW(17)) bus ();
    canal_lock_ctrl dut (.clk(clk), .reset(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural model of the lock
    int       m_lvl, m_phase, m_entry, m_ticks;
    bit       m_pend[2], m_led[2];
    bit       m_wrong;
    bit [5:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit openable(input int side, input int lvl);
        return (side == 0) ? (lvl <= TOL) : (lvl >= LVL_IN - TOL);
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_phase = P_FREE; m_entry = 0; m_ticks = 0;
        m_pend[0] = 0; m_pend[1] = 0; m_led[0] = 0; m_led[1] = 0;
        m_wrong = 0; m_prev = '0;
    endtask

    task automatic model_edge();
        bit [5:0] cur, ev;
        bit arr[2], door[2];
        bit inc_e, dec_e, auto_on;
        int old_lvl, old_ticks, s, x, nxt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        cur = {bus.outer_arrival_sw, bus.inner_arrival_sw, bus.outer_door_sw, bus.inner_door_sw,
               bus.inc_water_level, bus.dec_water_level};
        ev = cur & ~m_prev;
        m_prev = cur;
        arr[0] = ev[5]; arr[1] = ev[4]; door[0] = ev[3]; door[1] = ev[2];
        inc_e = ev[1]; dec_e = ev[0];
        old_lvl = m_lvl; old_ticks = m_ticks; s = m_entry; x = 1 - s;
        m_wrong = 0;
        if (bus.tick) m_ticks = (m_ticks < DLY) ? m_ticks + 1 : DLY;

        auto_on = 0;
`ifdef LOCK_AUTO_LEVEL_EN
        auto_on = (m_phase == P_POUND);
        if (auto_on && bus.tick) begin
            if (x == 1) m_lvl = (m_lvl + FILL > LVL_IN) ? LVL_IN : m_lvl + FILL;
            else        m_lvl = (m_lvl < DRAIN) ? 0 : m_lvl - DRAIN;
        end
`endif
        if (!auto_on) begin
            if (inc_e && !dec_e)      m_lvl = (m_lvl + FILL > LVL_IN) ? LVL_IN : m_lvl + FILL;
            else if (dec_e && !inc_e) m_lvl = (m_lvl < DRAIN) ? 0 : m_lvl - DRAIN;
        end

        if (m_phase != P_FREE) begin
            m_pend[0] |= arr[0];
            m_pend[1] |= arr[1];
        end
        case (m_phase)
            P_FREE: begin
                if (arr[0]) begin
                    m_phase = P_WAIT; m_entry = 0; m_led[0] = 1; m_ticks = 0; m_pend[1] = arr[1];
                end else if (arr[1]) begin
                    m_phase = P_WAIT; m_entry = 1; m_led[1] = 1; m_ticks = 0;
                end
            end
            P_WAIT: begin
                if (door[x]) m_wrong = 1;
                if (door[s]) begin
                    if (old_ticks >= DLY && openable(s, old_lvl)) begin
                        m_phase = P_POUND; m_led[0] = 1; m_led[1] = 1;
                    end else m_wrong = 1;
                end
            end
            P_POUND: begin
                if (door[s]) m_wrong = 1;
                if (door[x]) begin
                    if (openable(x, old_lvl)) begin
                        m_phase = P_EXIT; m_ticks = 0; m_led[x] = 1; m_led[s] = 0;
                    end else m_wrong = 1;
                end
            end
            default: begin
                if (door[0] || door[1]) m_wrong = 1;
                if (old_ticks >= DLY) begin
                    m_led[0] = 0; m_led[1] = 0;
                    if (m_pend[0] || m_pend[1]) begin
                        nxt = (m_pend[0] && m_pend[1]) ? x : (m_pend[1] ? 1 : 0);
                        m_pend[nxt] = 0; m_entry = nxt; m_phase = P_WAIT;
                        m_led[nxt] = 1; m_ticks = 0;
                    end else m_phase = P_FREE;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".level"}, 32'(bus.water_level), m_lvl);
        chk({tag, ".outer_open"}, 32'(bus.outer_door_openable_led), 32'(m_lvl <= TOL));
        chk({tag, ".inner_open"}, 32'(bus.inner_door_openable_led), 32'(m_lvl >= LVL_IN - TOL));
        chk({tag, ".outer_led"}, 32'(bus.outer_gondola_led), 32'(m_led[0]));
        chk({tag, ".inner_led"}, 32'(bus.inner_gondola_led), 32'(m_led[1]));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_phase != P_FREE));
        chk({tag, ".wrong"}, 32'(bus.wrong_cmd), 32'(m_wrong));
    endtask

    task automatic cyc(input logic [6:0] v, input string tag);
        bus.outer_arrival_sw = v[6]; bus.inner_arrival_sw = v[5];
        bus.outer_door_sw = v[4];    bus.inner_door_sw = v[3];
        bus.inc_water_level = v[2];  bus.dec_water_level = v[1];
        bus.tick = v[0];
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic pulse(input logic [6:0] v, input string tag);
        cyc(v, tag);
        cyc(NONE, tag);
    endtask

    task automatic ticks(input int n, input string tag);
        repeat (n) cyc(TK, tag);
    endtask

    initial begin
        logic [6:0] v;
        reset_n = 1'b0;
        model_reset();
        cyc(NONE, "rst");
        cyc(NONE, "rst");
        chk("rst_level", 32'(bus.water_level), 0);
        chk("rst_outer_open", 32'(bus.outer_door_openable_led), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        reset_n = 1'b1;

        // T2: full inward transit
        pulse(OA, "t2_arr");
        chk("t2_arrive_led", 32'({bus.outer_gondola_led, bus.inner_gondola_led}), 2'b10);
        ticks(DLY, "t2_wait");
        pulse(OD, "t2_entry");
        chk("t2_pound_leds", 32'({bus.outer_gondola_led, bus.inner_gondola_led}), 2'b11);
        repeat (8) pulse(INC | TK, "t2_fill");
        chk("t2_level_full", 32'(bus.water_level), LVL_IN);
        chk("t2_inner_open", 32'(bus.inner_door_openable_led), 1);
        pulse(ID, "t2_exit");
        chk("t2_depart_leds", 32'({bus.outer_gondola_led, bus.inner_gondola_led}), 2'b01);
        ticks(DLY, "t2_dept");
        cyc(NONE, "t2_clear");
        chk("t2_idle", 32'({bus.busy, bus.outer_gondola_led, bus.inner_gondola_led}), 0);

        // T3: early door rejected, later accepted
        repeat (7) pulse(DEC, "t3_drain");
        pulse(OA, "t3_arr");
        ticks(3, "t3_wait");
        cyc(OD, "t3_early");
        chk("t3_wrong_pulse", 32'(bus.wrong_cmd), 1);
        chk("t3_still_arrive", 32'(bus.inner_gondola_led), 0);
        cyc(NONE, "t3_rel");
        chk("t3_wrong_drop", 32'(bus.wrong_cmd), 0);
        ticks(2, "t3_wait2");
        pulse(OD, "t3_entry");
        chk("t3_pound", 32'({bus.outer_gondola_led, bus.inner_gondola_led}), 2'b11);
        repeat (8) pulse(INC | TK, "t3_fill");
        pulse(ID, "t3_exit");
        ticks(DLY, "t3_dept");
        cyc(NONE, "t3_clear");

        // T4: saturation
        repeat (10) pulse(DEC, "t4_dec0");
        chk("t4_floor", 32'(bus.water_level), 0);
        repeat (9) pulse(INC, "t4_inc");
        chk("t4_ceiling", 32'(bus.water_level), LVL_IN);
        repeat (10) pulse(DEC, "t4_dec");
        chk("t4_floor2", 32'(bus.water_level), 0);
        repeat (4) pulse(INC, "t4_mid");
        pulse(INC | DEC, "t4_both");
        chk("t4_both_hold", 32'(bus.water_level), 1400);
        repeat (4) pulse(DEC, "t4_back");

        // T5: both sides queue during DEPART, alternation on clear
        pulse(OA, "t5_arr");
        ticks(DLY, "t5_wait");
        pulse(OD, "t5_entry");
        repeat (8) pulse(INC | TK, "t5_fill");
        pulse(ID, "t5_exit");
        pulse(IA | OA, "t5_queue");
        ticks(DLY, "t5_dept");
        cyc(NONE, "t5_clear");
        chk("t5_inner_first", 32'({bus.busy, bus.outer_gondola_led, bus.inner_gondola_led}), 3'b101);
        ticks(DLY, "t5_wait2");
        pulse(ID, "t5_entry2");
        repeat (7) pulse(DEC | TK, "t5_drain");
        pulse(OD, "t5_exit2");
        chk("t5_depart_out", 32'({bus.outer_gondola_led, bus.inner_gondola_led}), 2'b10);
        ticks(DLY, "t5_dept2");
        cyc(NONE, "t5_clear2");
        chk("t5_outer_next", 32'({bus.busy, bus.outer_gondola_led, bus.inner_gondola_led}), 3'b110);
        ticks(DLY, "t5_wait3");
        pulse(OD, "t5_entry3");
        repeat (8) pulse(INC | TK, "t5_fill3");
        pulse(ID, "t5_exit3");
        ticks(DLY, "t5_dept3");
        cyc(NONE, "t5_clear3");
        chk("t5_idle", 32'(bus.busy), 0);

        // T1: reset mid-POUND, then an input held through reset
        pulse(OA, "t1_arr");
        repeat (7) pulse(DEC, "t1_drain");
        ticks(DLY, "t1_wait");
        pulse(OD, "t1_entry");
        repeat (3) pulse(INC, "t1_fill");
        reset_n = 1'b0;
        cyc(NONE, "t1_rst");
        chk("t1_level", 32'(bus.water_level), 0);
        chk("t1_leds", 32'({bus.outer_gondola_led, bus.inner_gondola_led}), 0);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_outer_open", 32'(bus.outer_door_openable_led), 1);
        cyc(OA, "t1_hold");
        reset_n = 1'b1;
        cyc(OA, "t1_release");
        chk("t1_held_arrival", 32'(bus.busy), 1);
        reset_n = 1'b0;
        cyc(NONE, "t1_rst2");
        reset_n = 1'b1;

`ifdef LOCK_AUTO_LEVEL_EN
        // T6: auto-level in POUND, manual ignored
        pulse(OA, "t6_arr");
        ticks(DLY, "t6_wait");
        pulse(OD, "t6_entry");
        ticks(8, "t6_auto");
        chk("t6_auto_full", 32'(bus.water_level), LVL_IN);
        pulse(DEC, "t6_dec");
        chk("t6_dec_ignored", 32'(bus.water_level), LVL_IN);
        reset_n = 1'b0;
        cyc(NONE, "t6_rst");
        reset_n = 1'b1;
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(499) != 0);
            v = 7'($urandom) & 7'($urandom) & 7'b1111110;
            v[0] = 1'($urandom_range(1));
            cyc(v, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
